// File: rtl/decode_seq_if.sv
// Instruction/data-RAM handshake and control-output bundle shared by the decode sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the RAM/datapath side.
interface decode_seq_if #(
  parameter int RW = 3,
  parameter int IW = 7 + 3 * RW
);
  localparam int NREG = 1 << RW;

  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic            COND_result;
  logic            mem_ready;
  logic            resume;

  logic [NREG-1:0] R_en;
  logic            R0_count;
  logic [RW-1:0]   s1;
  logic [RW-1:0]   s2;
  logic [RW-1:0]   s3;
  logic            s4;
  logic            RAMd_wren;
  logic            RAMd_en;
  logic            RAMi_en;
  logic            ALU_en;
  logic [1:0]      state;
  logic [15:0]     retired;

  modport master (
    input  instr, instr_valid, COND_result, mem_ready, resume,
    output R_en, R0_count, s1, s2, s3, s4,
           RAMd_wren, RAMd_en, RAMi_en, ALU_en, state, retired
  );

  modport slave (
    output instr, instr_valid, COND_result, mem_ready, resume,
    input  R_en, R0_count, s1, s2, s3, s4,
           RAMd_wren, RAMd_en, RAMi_en, ALU_en, state, retired
  );
endinterface

// File: rtl/decode_seq.sv
// Multi-cycle instruction decode sequencer: FETCH / EXEC1 / EXEC2 / HALT with register-enable generation.
// Optional retired-instruction counter enabled by defining DECODE_SEQ_RETIRE_CNT_EN.
module decode_seq #(
  parameter int RW      = 3,
  parameter int IW      = 16,
  parameter int MUL_LAT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  decode_seq_if.master bus
);

  localparam int NREG = 1 << RW;
  localparam logic [1:0] MUL_CNT = 2'(MUL_LAT - 1);
  localparam logic [IW-1:0] NOP_WORD = {1'b0, 6'b111110, {(3*RW){1'b0}}};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic [IW-1:0] ir_q;
  logic          ir_load;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_nxt;

  logic          msb;
  logic          ls;
  logic [5:0]    op;
  logic [RW-1:0] rls;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs1;
  logic [RW-1:0] rs2;

  logic is_ujmp;
  logic is_jmp;
  logic is_mul;
  logic is_nop;
  logic is_stp;
  logic is_alu;
  logic is_load;
  logic is_store;
  logic is_mem;
  logic complete;

  assign msb = ir_q[IW-1];
  assign ls  = ir_q[IW-2];
  assign op  = ir_q[IW-2 -: 6];
  assign rls = ir_q[IW-3 -: RW];
  assign rd  = ir_q[3*RW-1 -: RW];
  assign rs1 = ir_q[2*RW-1 -: RW];
  assign rs2 = ir_q[RW-1:0];

  // Instruction classes; anything in the register space not otherwise named is an ALU op.
  assign is_ujmp  = !msb && (op[5:2] == 4'b0000);
  assign is_jmp   = !msb && ((op[5:2] == 4'b0001) || (op[5:2] == 4'b0010));
  assign is_mul   = !msb && ((op == 6'b011100) || (op == 6'b011101) || (op == 6'b011110));
  assign is_nop   = !msb && (op == 6'b111110);
  assign is_stp   = !msb && (op == 6'b111111);
  assign is_alu   = !msb && !(is_ujmp || is_jmp || is_mul || is_nop || is_stp);
  assign is_load  = msb && !ls;
  assign is_store = msb && ls;
  assign is_mem   = msb;

  // The one EXEC1 cycle per instruction where single-shot pulses are allowed.
  assign complete = (state_q == EXEC1) && !(is_mem && !bus.mem_ready);

  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      ir_q    <= NOP_WORD;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (ir_load) begin
        ir_q <= bus.instr;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    ir_load   = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          state_nxt = EXEC1;
          ir_load   = 1'b1;
        end
      end
      EXEC1: begin
        if (is_stp) begin
          state_nxt = HALT;
        end else if (is_mem && !bus.mem_ready) begin
          state_nxt = EXEC1;
        end else if (is_load || is_mul) begin
          state_nxt = EXEC2;
          cnt_nxt   = is_mul ? MUL_CNT : 2'd0;
        end else begin
          state_nxt = FETCH;
        end
      end
      EXEC2: begin
        if (cnt_q != 2'd0) begin
          cnt_nxt = cnt_q - 2'd1;
        end else begin
          state_nxt = FETCH;
        end
      end
      HALT: begin
        if (bus.resume) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  logic [NREG-1:0] r_en;
  logic            r0_count;
  logic [RW-1:0]   sel1;
  logic [RW-1:0]   sel2;
  logic [RW-1:0]   sel3;
  logic            sel4;
  logic            ramd_wren;
  logic            ramd_en;
  logic            rami_en;
  logic            alu_en;

  // Register writes land either at EXEC1 completion or in the last EXEC2 cycle, never both.
  always_comb begin
    r_en      = '0;
    r0_count  = 1'b0;
    sel1      = '0;
    sel2      = '0;
    sel3      = '0;
    sel4      = 1'b0;
    ramd_wren = 1'b0;
    ramd_en   = 1'b0;
    rami_en   = 1'b0;
    alu_en    = 1'b0;
    case (state_q)
      FETCH: begin
        rami_en = 1'b1;
      end
      EXEC1: begin
        sel4    = !is_mem;
        ramd_en = is_mem;
        alu_en  = is_mem;
        if (is_alu || is_mul) begin
          sel1 = rs1;
          sel2 = rs2;
          sel3 = rd;
        end else if (is_store) begin
          sel1 = rls;
        end
        if (complete) begin
          r0_count  = !(is_ujmp || is_jmp || is_stp);
          ramd_wren = is_store;
          if (is_alu) begin
            r_en = onehot(rd);
          end else if (is_ujmp || (is_jmp && bus.COND_result)) begin
            r_en = onehot('0);
          end
        end
      end
      EXEC2: begin
        sel4   = !is_mem;
        alu_en = is_mem;
        if (cnt_q == 2'd0) begin
          if (is_load) begin
            r_en = onehot(rls);
          end else if (is_mul) begin
            r_en = onehot(rd);
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.R_en      = r_en;
  assign bus.R0_count  = r0_count;
  assign bus.s1        = sel1;
  assign bus.s2        = sel2;
  assign bus.s3        = sel3;
  assign bus.s4        = sel4;
  assign bus.RAMd_wren = ramd_wren;
  assign bus.RAMd_en   = ramd_en;
  assign bus.RAMi_en   = rami_en;
  assign bus.ALU_en    = alu_en;
  assign bus.state     = state_q;

`ifdef DECODE_SEQ_RETIRE_CNT_EN
  logic [15:0] retired_q;
  logic        retire_evt;

  // An instruction retires when execution hands back to FETCH or stops in HALT.
  assign retire_evt = ((state_q == EXEC1) || (state_q == EXEC2)) &&
                      ((state_nxt == FETCH) || (state_nxt == HALT));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      retired_q <= 16'd0;
    end else if (retire_evt) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = 16'd0;
`endif

endmodule
